// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port: A (fetch, read-only) and B (data, read/write).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties; default build gives B fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:1] a_m_addr,
  input  logic        a_m_access,
  output logic        a_m_ack,
  output logic [15:0] a_m_data_in,
  input  logic [19:1] b_m_addr,
  input  logic        b_m_access,
  input  logic        b_m_wr_en,
  input  logic [1:0]  b_m_bytesel,
  input  logic [15:0] b_m_data_out,
  output logic        b_m_ack,
  output logic [15:0] b_m_data_in,
  output logic [19:1] q_m_addr,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic [15:0] q_m_data_out,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t state;
  logic   grant_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 when B was the last requester acked; reset value A lets B win the first tie.
  logic last_b;
`endif

  always_comb begin
    grant_b = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (a_m_access && b_m_access)
      grant_b = !last_b;
    else
      grant_b = b_m_access;
`else
    grant_b = b_m_access;
`endif
  end

  // Grant is fixed on entry to SERVE_x and held until the slave acks, even if
  // the requester drops access early; TURN gives the requester a cycle to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_b <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (a_m_access || b_m_access)
            state <= grant_b ? SERVE_B : SERVE_A;
        end
        SERVE_A: begin
          if (q_m_ack) begin
            state <= TURN;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_b <= 1'b0;
`endif
          end
        end
        SERVE_B: begin
          if (q_m_ack) begin
            state <= TURN;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_b <= 1'b1;
`endif
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shared-port drive and ack/data return follow the registered state only,
  // so reset clears every output at once and stray acks outside SERVE_x vanish.
  always_comb begin
    q_m_addr     = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_m_data_out = 16'h0000;
    a_m_ack      = 1'b0;
    a_m_data_in  = 16'h0000;
    b_m_ack      = 1'b0;
    b_m_data_in  = 16'h0000;
    case (state)
      SERVE_A: begin
        q_m_addr    = a_m_addr;
        q_m_access  = 1'b1;
        q_m_bytesel = 2'b11;
        a_m_ack     = q_m_ack;
        a_m_data_in = q_m_data_in;
      end
      SERVE_B: begin
        q_m_addr     = b_m_addr;
        q_m_access   = 1'b1;
        q_m_wr_en    = b_m_wr_en;
        q_m_bytesel  = b_m_bytesel;
        q_m_data_out = b_m_data_out;
        b_m_ack      = q_m_ack;
        b_m_data_in  = q_m_data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple variable-latency slave model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:1] a_m_addr;
  logic        a_m_access;
  logic        a_m_ack;
  logic [15:0] a_m_data_in;
  logic [19:1] b_m_addr;
  logic        b_m_access;
  logic        b_m_wr_en;
  logic [1:0]  b_m_bytesel;
  logic [15:0] b_m_data_out;
  logic        b_m_ack;
  logic [15:0] b_m_data_in;
  logic [19:1] q_m_addr;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic [15:0] q_m_data_out;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic        slave_en;
  int          slave_lat;
  logic [15:0] slave_rdata;
  int          scnt = 0;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_m_addr(a_m_addr), .a_m_access(a_m_access), .a_m_ack(a_m_ack), .a_m_data_in(a_m_data_in),
    .b_m_addr(b_m_addr), .b_m_access(b_m_access), .b_m_wr_en(b_m_wr_en),
    .b_m_bytesel(b_m_bytesel), .b_m_data_out(b_m_data_out), .b_m_ack(b_m_ack),
    .b_m_data_in(b_m_data_in),
    .q_m_addr(q_m_addr), .q_m_access(q_m_access), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_m_data_out(q_m_data_out), .q_m_ack(q_m_ack),
    .q_m_data_in(q_m_data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: acks in the slave_lat-th cycle that q_m_access is high.
  always begin
    @(posedge clk);
    #1;
    if (slave_en) begin
      q_m_ack = 1'b0;
      if (q_m_access) begin
        scnt++;
        if (scnt >= slave_lat) begin
          q_m_ack     = 1'b1;
          q_m_data_in = slave_rdata;
          scnt        = 0;
        end
      end else begin
        scnt = 0;
      end
    end
  end

  initial begin
    logic [3:0] seq;
    int         ngrant;
    logic [3:0] exp_seq;

    reset_n = 1'b0;
    a_m_addr = '0; a_m_access = 1'b0;
    b_m_addr = '0; b_m_access = 1'b0; b_m_wr_en = 1'b0; b_m_bytesel = 2'b00; b_m_data_out = 16'h0;
    q_m_ack = 1'b0; q_m_data_in = 16'h0;
    slave_en = 1'b1; slave_lat = 1; slave_rdata = 16'h0;

    // Reset holds everything quiet even with requests pending
    a_m_access = 1'b1; b_m_access = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q_access", 32'(q_m_access), 32'd0);
    chk("rst_q_addr",   32'(q_m_addr),   32'd0);
    chk("rst_a_ack",    32'(a_m_ack),    32'd0);
    chk("rst_b_ack",    32'(b_m_ack),    32'd0);
    a_m_access = 1'b0; b_m_access = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_q_access", 32'(q_m_access), 32'd0);

    // A-only read, latency 1
    a_m_addr = 19'h7FFF0; a_m_access = 1'b1; slave_rdata = 16'hEA5B; slave_lat = 1;
    @(negedge clk);
    chk("a_q_access",  32'(q_m_access),   32'd1);
    chk("a_q_addr",    32'(q_m_addr),     32'h7FFF0);
    chk("a_q_wr_en",   32'(q_m_wr_en),    32'd0);
    chk("a_q_bytesel", 32'(q_m_bytesel),  32'h3);
    chk("a_q_dout",    32'(q_m_data_out), 32'h0);
    chk("a_ack",       32'(a_m_ack),      32'd1);
    chk("a_data",      32'(a_m_data_in),  32'hEA5B);
    chk("a_b_ack",     32'(b_m_ack),      32'd0);
    chk("a_b_data",    32'(b_m_data_in),  32'h0);
    a_m_access = 1'b0;
    @(negedge clk);
    chk("a_turn_access", 32'(q_m_access), 32'd0);
    chk("a_turn_ack",    32'(a_m_ack),    32'd0);
    @(negedge clk);
    chk("a_idle_access", 32'(q_m_access), 32'd0);

    // B write, latency 2
    b_m_addr = 19'h00100; b_m_data_out = 16'h1234; b_m_bytesel = 2'b01; b_m_wr_en = 1'b1;
    b_m_access = 1'b1; slave_lat = 2; slave_rdata = 16'hFFFF;
    @(negedge clk);
    chk("b_q_access",  32'(q_m_access),   32'd1);
    chk("b_q_addr",    32'(q_m_addr),     32'h00100);
    chk("b_q_wr_en",   32'(q_m_wr_en),    32'd1);
    chk("b_q_bytesel", 32'(q_m_bytesel),  32'h1);
    chk("b_q_dout",    32'(q_m_data_out), 32'h1234);
    chk("b_ack_early", 32'(b_m_ack),      32'd0);
    @(negedge clk);
    chk("b_ack",       32'(b_m_ack),      32'd1);
    chk("b_a_ack",     32'(a_m_ack),      32'd0);
    chk("b_a_data",    32'(a_m_data_in),  32'h0);
    b_m_access = 1'b0; b_m_wr_en = 1'b0;
    @(negedge clk);
    chk("b_turn_access", 32'(q_m_access),   32'd0);
    chk("b_turn_wr_en",  32'(q_m_wr_en),    32'd0);
    chk("b_turn_dout",   32'(q_m_data_out), 32'h0);
    @(negedge clk);

    // Simultaneous held requests after a fresh reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    slave_lat = 1; slave_rdata = 16'h0101;
    a_m_addr = 19'h00AAA; b_m_addr = 19'h00BBB; b_m_bytesel = 2'b11;
    a_m_access = 1'b1; b_m_access = 1'b1;
    seq = 4'b0; ngrant = 0;
    for (int cyc = 0; cyc < 40 && ngrant < 4; cyc++) begin
      @(negedge clk);
      if (a_m_ack && b_m_ack) chk("tie_both_ack", 32'd1, 32'd0);
      if (a_m_ack || b_m_ack) begin
        seq[ngrant] = b_m_ack;
        ngrant++;
      end
    end
    a_m_access = 1'b0; b_m_access = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b0101;
`else
    exp_seq = 4'b1111;
`endif
    chk("tie_count", 32'(ngrant), 32'd4);
    chk("tie_order", 32'(seq),    32'(exp_seq));
    @(negedge clk);
    @(negedge clk);

    // Back-to-back A reads, latency 1: one access every third cycle
    a_m_addr = 19'h00040; a_m_access = 1'b1; slave_rdata = 16'h0F0F;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_access_%0d", i), 32'(q_m_access), (i % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_ack_%0d", i),    32'(a_m_ack),    (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    a_m_access = 1'b0;
    @(negedge clk);

    // Reset during SERVE_A before the slave answers
    slave_en = 1'b0; q_m_ack = 1'b0;
    a_m_addr = 19'h12345; a_m_access = 1'b1;
    @(negedge clk);
    chk("rmid_access",  32'(q_m_access), 32'd1);
    chk("rmid_no_ack",  32'(a_m_ack),    32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rmid_access_clr", 32'(q_m_access), 32'd0);
    chk("rmid_addr_clr",   32'(q_m_addr),   32'd0);
    chk("rmid_bytesel_clr", 32'(q_m_bytesel), 32'd0);
    a_m_access = 1'b0;
    q_m_ack = 1'b1; q_m_data_in = 16'hBEEF;
    #1;
    chk("rmid_ack_in_rst",  32'(a_m_ack),     32'd0);
    chk("rmid_data_in_rst", 32'(a_m_data_in), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rmid_late_ack",    32'(a_m_ack),    32'd0);
    chk("rmid_late_access", 32'(q_m_access), 32'd0);
    q_m_ack = 1'b0;
    slave_en = 1'b1; slave_lat = 1; slave_rdata = 16'h5A5A;
    a_m_access = 1'b1;
    @(negedge clk);
    chk("rmid_next_ack",  32'(a_m_ack),     32'd1);
    chk("rmid_next_data", 32'(a_m_data_in), 32'h5A5A);
    chk("rmid_next_addr", 32'(q_m_addr),    32'h12345);
    a_m_access = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters: none.
REQ-001 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL provide port: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide port: a_m_addr  input  19 [19:1]  requester A (instruction fetch, read-only) word address.
REQ-004 SHALL provide port: a_m_access  input  1  requester A request, held until a_m_ack.
REQ-005 SHALL provide port: a_m_ack  output  1  requester A completion, one cycle.
REQ-006 SHALL provide port: a_m_data_in  output  16  read data to A, valid with a_m_ack.
REQ-007 SHALL provide port: b_m_addr  input  19 [19:1]  requester B (data, read/write) word address.
REQ-008 SHALL provide port: b_m_access  input  1  requester B request, held until b_m_ack.
REQ-009 SHALL provide port: b_m_wr_en  input  1  B write when 1, read when 0.
REQ-010 SHALL provide port: b_m_bytesel  input  2  B byte lanes.
REQ-011 SHALL provide port: b_m_data_out  input  16  B write data.
REQ-012 SHALL provide port: b_m_ack  output  1  requester B completion, one cycle.
REQ-013 SHALL provide port: b_m_data_in  output  16  read data to B, valid with b_m_ack.
REQ-014 SHALL provide port: q_m_addr  output  19 [19:1]  shared-port address.
REQ-015 SHALL provide port: q_m_access  output  1  shared-port request.
REQ-016 SHALL provide port: q_m_wr_en  output  1  shared-port write enable.
REQ-017 SHALL provide port: q_m_bytesel  output  2  shared-port byte lanes.
REQ-018 SHALL provide port: q_m_data_out  output  16  shared-port write data.
REQ-019 SHALL provide port: q_m_ack  input  1  shared-port completion, one cycle, any latency >= 1.
REQ-020 SHALL provide port: q_m_data_in  input  16  shared-port read data, valid with q_m_ack.

Function
REQ-021 SHALL implement registered FSM: IDLE, SERVE_A, SERVE_B, TURN.
REQ-022 IDLE: sample a_m_access/b_m_access; none -> stay IDLE; otherwise -> SERVE_A or SERVE_B per grant policy (REQ-030/031).
REQ-023 SERVE_x: q_m_access=1, q_m_addr/wr_en/bytesel/data_out driven combinationally from requester x; A path: q_m_wr_en=0, q_m_bytesel=2'b11, q_m_data_out=0.
REQ-024 SERVE_x: q_m_ack forwarded combinationally to x_m_ack in same cycle; q_m_data_in to x_m_data_in in same cycle; next state TURN.
REQ-025 TURN: one cycle, q_m_access=0, no requests sampled (allows requester to drop access); next state IDLE.
REQ-026 Latency: access sampled in IDLE at edge N -> q_m_access high in cycle N+1; minimum transaction-to-transaction period = slave latency + 2 cycles.
REQ-027 Non-granted requester: ack=0, data_in=16'h0000; all q_m_* outputs 0 in IDLE and TURN.
REQ-028 Grant latched on entry to SERVE_x; requests arriving during SERVE_x/TURN wait; no preemption.
REQ-029 Requester dropping access before ack (protocol violation): arbiter stays in SERVE_x until q_m_ack, no hang beyond slave ack.

Configuration
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined: 1-bit last-grant register updated on each ack; simultaneous requests in IDLE granted to requester not served last; reset value = last served A (so B wins first tie).
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, B over A on simultaneous requests; no last-grant register.

Reset
REQ-032 reset_n low SHALL asynchronously force state IDLE, all outputs 0, last-grant register to A, including mid-transaction; slave ack arriving during or after reset SHALL be ignored until a new grant.
REQ-033 Deassertion of reset_n SHALL take effect on the next rising clk; first request sampled at that edge.

Verification
REQ-034 A-only read, addr 19'h7FFF0, slave acks 1 cycle after q_m_access with 16'hEA5B -> q_m_access in cycle N+1, a_m_ack=1 and a_m_data_in=16'hEA5B same cycle as q_m_ack, b_m_ack=0.
REQ-035 B write addr 19'h00100, data 16'h1234, bytesel 2'b01 -> q_m_wr_en=1, q_m_bytesel=2'b01, q_m_data_out=16'h1234 while SERVE_B; b_m_ack on q_m_ack.
REQ-036 A and B assert same cycle, held continuously, 4 transactions -> fixed-priority build: B,B,B,B (A starved); round-robin build: B,A,B,A.
REQ-037 reset_n pulsed low during SERVE_A before q_m_ack -> outputs 0 immediately, late q_m_ack produces no a_m_ack, next request served normally.
REQ-038 Back-to-back A reads, slave latency 1 -> q_m_access high every 3rd cycle, q_m_access low in TURN and IDLE cycles.
